// File: rtl/pla_vg2_sig_compactor.sv
// rtl/pla_vg2_sig_compactor.sv - 16-bit MISR response compactor for the vg2 PLA self-test
//
// Purpose:
//   Folds N_PATTERNS PLA output vectors (one per i_z_valid strobe) into a
//   16-bit MISR seeded with SEED. It then flags completion and compares the
//   result against EXPECTED.
//   Optional build macro: PLA_VG2_TOGGLE_COV_EN adds per-bit toggle coverage
//   outputs. The signature behaviour is the same in both builds.
//
// Parameters:
//   N_PATTERNS  vectors folded per run (1..65535)
//   SEED        MISR value loaded on reset and on every accepted start
//   EXPECTED    golden signature used for o_pass
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        begin a run; sampled in IDLE and DONE only
//   i_z_in[7:0]    PLA outputs {z7..z0}
//   i_z_valid      i_z_in holds a valid PLA result this cycle
//   o_busy         high while a run is in progress
//   o_done         high after the final vector until the next start or reset
//   o_pass         o_done and the signature equals EXPECTED
//   o_signature    current MISR contents
//   o_count        vectors accepted in the current run
//   o_cov_seen0    (PLA_VG2_TOGGLE_COV_EN) bit i has been observed at 0
//   o_cov_seen1    (PLA_VG2_TOGGLE_COV_EN) bit i has been observed at 1
//   o_cov_full     (PLA_VG2_TOGGLE_COV_EN) every bit has been seen at both values

module pla_vg2_sig_compactor #(
  parameter int unsigned N_PATTERNS = 256,
  parameter logic [15:0] SEED       = 16'hFFFF,
  parameter logic [15:0] EXPECTED   = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_z_in,
  input  logic        i_z_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_signature,
  output logic [15:0] o_count
`ifdef PLA_VG2_TOGGLE_COV_EN
  ,
  output logic [7:0]  o_cov_seen0,
  output logic [7:0]  o_cov_seen1,
  output logic        o_cov_full
`endif
);

  // Count value, before the increment, at which the final vector of a run arrives.
  localparam logic [15:0] LP_LAST = 16'(N_PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_sig;
  logic [15:0] r_count;
  logic        r_busy;
  logic        r_done;
  logic [15:0] w_sig_next;

`ifdef PLA_VG2_TOGGLE_COV_EN
  logic [7:0]  r_seen0;
  logic [7:0]  r_seen1;
`endif

  // Shift left. Fold in polynomial 0x1021 when the MSB falls out, then XOR the vector into the low byte.
  assign w_sig_next = {r_sig[14:0], 1'b0}
                    ^ (r_sig[15] ? 16'h1021 : 16'h0000)
                    ^ {8'h00, i_z_in};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_count <= 16'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PLA_VG2_TOGGLE_COV_EN
      r_seen0 <= 8'h00;
      r_seen1 <= 8'h00;
`endif
    end else begin
      case (r_state)
        // A start in IDLE or DONE takes priority over a coincident z_valid.
        // The vector that arrives in that cycle is dropped.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_sig   <= SEED;
            r_count <= 16'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef PLA_VG2_TOGGLE_COV_EN
            r_seen0 <= 8'h00;
            r_seen1 <= 8'h00;
`endif
          end
        end
        S_RUN: begin
          if (i_z_valid) begin
            r_sig   <= w_sig_next;
            r_count <= r_count + 16'd1;
`ifdef PLA_VG2_TOGGLE_COV_EN
            r_seen0 <= r_seen0 | ~i_z_in;
            r_seen1 <= r_seen1 | i_z_in;
`endif
            if (r_count == LP_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_done & (r_sig == EXPECTED);
  assign o_signature = r_sig;
  assign o_count     = r_count;

`ifdef PLA_VG2_TOGGLE_COV_EN
  assign o_cov_seen0 = r_seen0;
  assign o_cov_seen1 = r_seen1;
  assign o_cov_full  = &{r_seen0, r_seen1};
`endif

endmodule

// File: tb/tb_pla_vg2_sig_compactor.sv
// tb/tb_pla_vg2_sig_compactor.sv - directed self-checking bench for pla_vg2_sig_compactor

module tb_pla_vg2_sig_compactor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] z_in = 8'h00;
  logic       z_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // u1: N=1 SEED=FFFF ; u2: N=2 SEED=0 EXP=0110 ; u3: as u2 but EXP=0111 ; u4: N=256 SEED=FFFF
  logic        u1_busy, u1_done, u1_pass;
  logic [15:0] u1_sig, u1_cnt;
  logic        u2_busy, u2_done, u2_pass;
  logic [15:0] u2_sig, u2_cnt;
  logic        u3_busy, u3_done, u3_pass;
  logic [15:0] u3_sig, u3_cnt;
  logic        u4_busy, u4_done, u4_pass;
  logic [15:0] u4_sig, u4_cnt;
`ifdef PLA_VG2_TOGGLE_COV_EN
  logic [7:0]  u1_s0, u1_s1, u2_s0, u2_s1, u3_s0, u3_s1, u4_s0, u4_s1;
  logic        u1_full, u2_full, u3_full, u4_full;
`endif

  always #5 clk = ~clk;

  pla_vg2_sig_compactor #(.N_PATTERNS(1), .SEED(16'hFFFF), .EXPECTED(16'h0000)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_z_in(z_in), .i_z_valid(z_valid),
    .o_busy(u1_busy), .o_done(u1_done), .o_pass(u1_pass), .o_signature(u1_sig), .o_count(u1_cnt)
`ifdef PLA_VG2_TOGGLE_COV_EN
    , .o_cov_seen0(u1_s0), .o_cov_seen1(u1_s1), .o_cov_full(u1_full)
`endif
  );

  pla_vg2_sig_compactor #(.N_PATTERNS(2), .SEED(16'h0000), .EXPECTED(16'h0110)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_z_in(z_in), .i_z_valid(z_valid),
    .o_busy(u2_busy), .o_done(u2_done), .o_pass(u2_pass), .o_signature(u2_sig), .o_count(u2_cnt)
`ifdef PLA_VG2_TOGGLE_COV_EN
    , .o_cov_seen0(u2_s0), .o_cov_seen1(u2_s1), .o_cov_full(u2_full)
`endif
  );

  pla_vg2_sig_compactor #(.N_PATTERNS(2), .SEED(16'h0000), .EXPECTED(16'h0111)) u3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_z_in(z_in), .i_z_valid(z_valid),
    .o_busy(u3_busy), .o_done(u3_done), .o_pass(u3_pass), .o_signature(u3_sig), .o_count(u3_cnt)
`ifdef PLA_VG2_TOGGLE_COV_EN
    , .o_cov_seen0(u3_s0), .o_cov_seen1(u3_s1), .o_cov_full(u3_full)
`endif
  );

  pla_vg2_sig_compactor #(.N_PATTERNS(256), .SEED(16'hFFFF), .EXPECTED(16'h0000)) u4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_z_in(z_in), .i_z_valid(z_valid),
    .o_busy(u4_busy), .o_done(u4_done), .o_pass(u4_pass), .o_signature(u4_sig), .o_count(u4_cnt)
`ifdef PLA_VG2_TOGGLE_COV_EN
    , .o_cov_seen0(u4_s0), .o_cov_seen1(u4_s1), .o_cov_full(u4_full)
`endif
  );

  // Software MISR reference
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] z);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {8'h00, z};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; z_valid = 1'b0; z_in = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; z_valid = 1'b1; z_in = 8'hFF; start = 1'b0;
    step();
    n_tests++; if (u1_sig !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sig got=%h exp=ffff", u1_sig); end
    n_tests++; if (u2_sig !== 16'h0000) begin n_fail++; $display("FAIL reset_sig_u2 got=%h exp=0000", u2_sig); end
    n_tests++; if ({u1_busy, u1_done, u1_pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {u1_busy, u1_done, u1_pass}); end
    n_tests++; if (u1_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", u1_cnt); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (u1_sig !== 16'hFFFF || u1_cnt !== 16'd0 || {u1_busy, u1_done, u1_pass} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_hold sig=%h cnt=%0d flags=%b exp sig=ffff cnt=0 flags=000", u1_sig, u1_cnt, {u1_busy, u1_done, u1_pass});
      end
    end
    z_valid = 1'b0;
  endtask

  task automatic test_single_vector();
    do_reset();
    do_start();
    n_tests++; if (u1_busy !== 1'b1 || u1_done !== 1'b0) begin n_fail++; $display("FAIL single_busy busy=%b done=%b exp 1/0", u1_busy, u1_done); end
    z_in = 8'h00; z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    n_tests++; if (u1_sig !== 16'hEFDF) begin n_fail++; $display("FAIL single_sig got=%h exp=efdf", u1_sig); end
    n_tests++; if (u1_cnt !== 16'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", u1_cnt); end
    n_tests++; if (u1_done !== 1'b1 || u1_busy !== 1'b0 || u1_pass !== 1'b0) begin n_fail++; $display("FAIL single_done d=%b b=%b p=%b exp 1/0/0", u1_done, u1_busy, u1_pass); end
    z_in = 8'h55; z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    n_tests++; if (u1_sig !== 16'hEFDF || u1_cnt !== 16'd1 || u1_done !== 1'b1) begin n_fail++; $display("FAIL done_frozen sig=%h cnt=%0d done=%b exp efdf/1/1", u1_sig, u1_cnt, u1_done); end
  endtask

  task automatic test_two_vectors_gaps();
    do_reset();
    do_start();
    z_in = 8'hA5; z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    n_tests++; if (u2_sig !== 16'h00A5 || u2_cnt !== 16'd1) begin n_fail++; $display("FAIL gap_first sig=%h cnt=%0d exp 00a5/1", u2_sig, u2_cnt); end
    step(); step(); step();
    n_tests++; if (u2_sig !== 16'h00A5 || u2_busy !== 1'b1 || u2_done !== 1'b0) begin n_fail++; $display("FAIL gap_hold sig=%h busy=%b done=%b exp 00a5/1/0", u2_sig, u2_busy, u2_done); end
    z_in = 8'h5A; z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    n_tests++; if (u2_sig !== 16'h0110 || u2_cnt !== 16'd2) begin n_fail++; $display("FAIL gap_second sig=%h cnt=%0d exp 0110/2", u2_sig, u2_cnt); end
    n_tests++; if (u2_done !== 1'b1 || u2_pass !== 1'b1 || u2_busy !== 1'b0) begin n_fail++; $display("FAIL gap_pass d=%b p=%b b=%b exp 1/1/0", u2_done, u2_pass, u2_busy); end
    n_tests++; if (u3_done !== 1'b1 || u3_pass !== 1'b0) begin n_fail++; $display("FAIL gap_wrong_expected d=%b p=%b exp 1/0", u3_done, u3_pass); end
  endtask

  task automatic test_collisions();
    do_reset();
    do_start();
    z_in = 8'hA5; z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++; if (u2_busy !== 1'b1 || u2_cnt !== 16'd1 || u2_sig !== 16'h00A5) begin n_fail++; $display("FAIL midrun_start busy=%b cnt=%0d sig=%h exp 1/1/00a5", u2_busy, u2_cnt, u2_sig); end
    z_in = 8'h5A; z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    n_tests++; if (u2_done !== 1'b1 || u2_sig !== 16'h0110) begin n_fail++; $display("FAIL midrun_finish done=%b sig=%h exp 1/0110", u2_done, u2_sig); end
    start = 1'b1; z_valid = 1'b1; z_in = 8'h33;
    step();
    start = 1'b0; z_valid = 1'b0;
    n_tests++; if (u2_busy !== 1'b1 || u2_done !== 1'b0 || u2_pass !== 1'b0) begin n_fail++; $display("FAIL restart_flags b=%b d=%b p=%b exp 1/0/0", u2_busy, u2_done, u2_pass); end
    n_tests++; if (u2_sig !== 16'h0000 || u2_cnt !== 16'd0) begin n_fail++; $display("FAIL restart_discard sig=%h cnt=%0d exp 0000/0", u2_sig, u2_cnt); end
    z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    n_tests++; if (u2_sig !== 16'h0033 || u2_cnt !== 16'd1) begin n_fail++; $display("FAIL restart_fold sig=%h cnt=%0d exp 0033/1", u2_sig, u2_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] model;
    do_reset();
    do_start();
    model = 16'hFFFF;
    z_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      z_in = 8'(i * 37 + 1);
      model = misr(model, z_in);
      step();
    end
    z_valid = 1'b0;
    n_tests++; if (u4_cnt !== 16'd100 || u4_sig !== model) begin n_fail++; $display("FAIL partial_run cnt=%0d sig=%h exp 100/%h", u4_cnt, u4_sig, model); end
    z_valid = 1'b1; z_in = 8'h77; rst = 1'b1;
    step();
    rst = 1'b0; z_valid = 1'b0;
    n_tests++; if (u4_cnt !== 16'd0 || u4_sig !== 16'hFFFF || u4_busy !== 1'b0 || u4_done !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset cnt=%0d sig=%h busy=%b done=%b exp 0/ffff/0/0", u4_cnt, u4_sig, u4_busy, u4_done);
    end
    do_start();
    model = 16'hFFFF;
    z_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      z_in = 8'(i * 13) ^ 8'h5C;
      model = misr(model, z_in);
      step();
      if (i == 254) begin
        n_tests++; if (u4_done !== 1'b0 || u4_busy !== 1'b1) begin n_fail++; $display("FAIL early_done done=%b busy=%b exp 0/1", u4_done, u4_busy); end
      end
    end
    z_valid = 1'b0;
    n_tests++; if (u4_cnt !== 16'd256 || u4_sig !== model) begin n_fail++; $display("FAIL full_run cnt=%0d sig=%h exp 256/%h", u4_cnt, u4_sig, model); end
    n_tests++; if (u4_done !== 1'b1 || u4_busy !== 1'b0 || u4_pass !== (model == 16'h0000)) begin
      n_fail++; $display("FAIL full_run_flags done=%b busy=%b pass=%b exp 1/0/%b", u4_done, u4_busy, u4_pass, model == 16'h0000);
    end
  endtask

`ifdef PLA_VG2_TOGGLE_COV_EN
  task automatic test_toggle_cov();
    do_reset();
    n_tests++; if (u2_s0 !== 8'h00 || u2_s1 !== 8'h00 || u2_full !== 1'b0) begin n_fail++; $display("FAIL cov_reset s0=%h s1=%h full=%b exp 00/00/0", u2_s0, u2_s1, u2_full); end
    do_start();
    z_in = 8'h0F; z_valid = 1'b1;
    step();
    n_tests++; if (u1_s0 !== 8'hF0 || u1_s1 !== 8'h0F || u1_full !== 1'b0) begin n_fail++; $display("FAIL cov_single s0=%h s1=%h full=%b exp f0/0f/0", u1_s0, u1_s1, u1_full); end
    z_in = 8'hF0;
    step();
    z_valid = 1'b0;
    n_tests++; if (u2_s0 !== 8'hFF || u2_s1 !== 8'hFF || u2_full !== 1'b1) begin n_fail++; $display("FAIL cov_full s0=%h s1=%h full=%b exp ff/ff/1", u2_s0, u2_s1, u2_full); end
    n_tests++; if (u1_s0 !== 8'hF0 || u1_s1 !== 8'h0F) begin n_fail++; $display("FAIL cov_frozen s0=%h s1=%h exp f0/0f", u1_s0, u1_s1); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_vector();
    test_two_vectors_gaps();
    test_collisions();
    test_back_to_back();
`ifdef PLA_VG2_TOGGLE_COV_EN
    test_toggle_cov();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
